dcache_setassoc: RTL

Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement and per-thread miss listeners. It sits in the MMU stage after the D-TLB and in front of the shared memory port. It generalises the direct-mapped data cache to configurable ways, sets, line size and thread count. It keeps one outstanding fill per set and a separate store-commit port driven by the committer.

---
 rtl/dcache_setassoc_if.sv | 25 ++
 rtl/dcache_setassoc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_setassoc_if.sv
// Shared memory port of the set-associative data cache: fill and write-back
// requests from the cache, fill responses back from memory.
interface dcache_setassoc_if #(
  parameter int PADDR_W    = 20,
  parameter int LINE_BYTES = 16
);
  logic                      mem_req_ren;
  logic [PADDR_W-1:0]        mem_req_raddr;
  logic                      mem_req_wen;
  logic [PADDR_W-1:0]        mem_req_waddr;
  logic [8*LINE_BYTES-1:0]   mem_req_wcacheline;
  logic                      mem_rec_en;
  logic [PADDR_W-1:0]        mem_rec_addr;
  logic [8*LINE_BYTES-1:0]   mem_rec_cacheline;

  modport master (
    output mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
    input  mem_rec_en, mem_rec_addr, mem_rec_cacheline
  );

  modport slave (
    input  mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
    output mem_rec_en, mem_rec_addr, mem_rec_cacheline
  );
endinterface

// File: rtl/dcache_setassoc.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement, one outstanding fill per set and per-thread miss listeners.
module dcache_setassoc #(
  parameter int N_WAYS     = 2,
  parameter int N_SETS     = 4,
  parameter int LINE_BYTES = 16,
  parameter int N_THREADS  = 4,
  parameter int PADDR_W    = 20
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [(N_THREADS > 1 ? $clog2(N_THREADS) : 1)-1:0]  thread,
  input  logic [PADDR_W-1:0]                                  paddr,
  input  logic                                                flag_mem,
  input  logic                                                flag_store,
  input  logic                                                flag_isbyte,
  input  logic                                                dtlb_miss,
  output logic                                                miss,
  output logic [31:0]                                         data,
  output logic [N_THREADS-1:0]                                stalled,
  input  logic                                                store_en,
  input  logic                                                store_isbyte,
  input  logic [PADDR_W-1:0]                                  store_addr,
  input  logic [31:0]                                         store_data,
  output logic                                                store_ok,
  dcache_setassoc_if.master                                   mem
);
  localparam int OB = $clog2(LINE_BYTES);
  localparam int IB = $clog2(N_SETS);
  localparam int TB = PADDR_W - OB - IB;
  localparam int WW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int LW = 8 * LINE_BYTES;

  typedef logic [N_WAYS-1:0][WW-1:0] ages_t;

  logic [N_WAYS-1:0] valid_q [N_SETS], valid_d [N_SETS];
  logic [N_WAYS-1:0] dirty_q [N_SETS], dirty_d [N_SETS];
  logic [TB-1:0]     tag_q   [N_SETS][N_WAYS], tag_d [N_SETS][N_WAYS];
  logic [LW-1:0]     line_q  [N_SETS][N_WAYS], line_d [N_SETS][N_WAYS];
  ages_t             age_q   [N_SETS], age_d [N_SETS];
  logic [N_SETS-1:0] wait_q, wait_d;
  logic [TB-1:0]     rtag_q  [N_SETS], rtag_d [N_SETS];
  logic [WW-1:0]     vict_q  [N_SETS], vict_d [N_SETS];
  logic [N_THREADS-1:0] lis_v_q, lis_v_d;
  logic [IB-1:0]     lis_idx_q [N_THREADS], lis_idx_d [N_THREADS];

  logic                 miss_q, miss_d, ok_q, ok_d, ren_q, ren_d, wen_q, wen_d;
  logic [31:0]          data_q, data_d;
  logic [N_THREADS-1:0] stalled_q, stalled_d;
  logic [PADDR_W-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic [LW-1:0]        wline_q, wline_d;

  logic          sw_hit, lk_found, vic_found;
  logic [WW-1:0] sw_way, lk_way, vic_way;

  logic [IB-1:0] f_idx, s_idx, l_idx;
  logic [TB-1:0] f_tag, s_tag, l_tag;
  logic [OB+2:0] s_bpos, s_wpos, l_bpos, l_wpos;

  assign f_idx  = mem.mem_rec_addr[OB +: IB];
  assign f_tag  = mem.mem_rec_addr[OB+IB +: TB];
  assign s_idx  = store_addr[OB +: IB];
  assign s_tag  = store_addr[OB+IB +: TB];
  assign l_idx  = paddr[OB +: IB];
  assign l_tag  = paddr[OB+IB +: TB];
  assign s_bpos = {store_addr[OB-1:0], 3'b000};
  assign s_wpos = (s_bpos >> 3'd5) << 3'd5;
  assign l_bpos = {paddr[OB-1:0], 3'b000};
  assign l_wpos = (l_bpos >> 3'd5) << 3'd5;

  // Make way w MRU: every way younger than w's old age ages by one.
  function automatic ages_t touch(input ages_t a, input logic [WW-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < N_WAYS; i++) begin
      if (a[i] < a[w]) r[i] = a[i] + WW'(1);
      else             r[i] = a[i];
    end
    r[w] = {WW{1'b0}};
    return r;
  endfunction

  // Next state: fill, then store commit, then lookup, each seeing the previous phase.
  always_comb begin
    valid_d = valid_q;  dirty_d = dirty_q;  tag_d  = tag_q;   line_d    = line_q;
    age_d   = age_q;    wait_d  = wait_q;   rtag_d = rtag_q;  vict_d    = vict_q;
    lis_v_d = lis_v_q;  lis_idx_d = lis_idx_q;  stalled_d = stalled_q;
    data_d  = data_q;   raddr_d = raddr_q;  waddr_d = waddr_q;  wline_d = wline_q;
    miss_d  = 1'b0;     ok_d    = 1'b0;     ren_d  = 1'b0;    wen_d     = 1'b0;
    sw_hit  = 1'b0;     sw_way  = {WW{1'b0}};
    lk_found = 1'b0;    lk_way  = {WW{1'b0}};
    vic_found = 1'b0;   vic_way = {WW{1'b0}};

    if (mem.mem_rec_en && wait_q[f_idx] && (rtag_q[f_idx] == f_tag)) begin
      line_d[f_idx][vict_q[f_idx]]  = mem.mem_rec_cacheline;
      tag_d[f_idx][vict_q[f_idx]]   = rtag_q[f_idx];
      valid_d[f_idx][vict_q[f_idx]] = 1'b1;
      dirty_d[f_idx][vict_q[f_idx]] = 1'b0;
      wait_d[f_idx] = 1'b0;
      age_d[f_idx]  = touch(age_q[f_idx], vict_q[f_idx]);
      for (int t = 0; t < N_THREADS; t++) begin
        if (lis_v_q[t] && (lis_idx_q[t] == f_idx)) begin
          lis_v_d[t]   = 1'b0;
          stalled_d[t] = 1'b0;
        end else begin
          lis_v_d[t]   = lis_v_q[t];
        end
      end
    end else begin
      wait_d = wait_q;
    end

    if (store_en) begin
      for (int w = 0; w < N_WAYS; w++) begin
        if (!sw_hit && valid_d[s_idx][w] && (tag_d[s_idx][w] == s_tag)) begin
          sw_hit = 1'b1;
          sw_way = WW'(w);
        end else begin
          sw_hit = sw_hit;
        end
      end
      if (sw_hit) begin
        if (store_isbyte) line_d[s_idx][sw_way][s_bpos +: 8]  = store_data[7:0];
        else              line_d[s_idx][sw_way][s_wpos +: 32] = store_data;
        dirty_d[s_idx][sw_way] = 1'b1;
        age_d[s_idx] = touch(age_d[s_idx], sw_way);
        ok_d = 1'b1;
      end else begin
        ok_d = 1'b0;
      end
    end else begin
      ok_d = 1'b0;
    end

    if (flag_mem && !dtlb_miss) begin
      for (int w = 0; w < N_WAYS; w++) begin
        if (!lk_found && valid_d[l_idx][w] && (tag_d[l_idx][w] == l_tag)) begin
          lk_found = 1'b1;
          lk_way   = WW'(w);
        end else begin
          lk_found = lk_found;
        end
      end
      if (lk_found && !(flag_store && wait_d[l_idx])) begin
        age_d[l_idx] = touch(age_d[l_idx], lk_way);
        if (flag_store)       data_d = data_q;
        else if (flag_isbyte) data_d = {24'h000000, line_d[l_idx][lk_way][l_bpos +: 8]};
        else                  data_d = line_d[l_idx][lk_way][l_wpos +: 32];
      end else begin
        miss_d = 1'b1;
        if (!wait_d[l_idx]) begin
          // Victim: first invalid way, otherwise the LRU way (oldest age).
          for (int w = 0; w < N_WAYS; w++) begin
            if (!vic_found && !valid_d[l_idx][w]) begin
              vic_found = 1'b1;
              vic_way   = WW'(w);
            end else begin
              vic_found = vic_found;
            end
          end
          for (int w = 0; w < N_WAYS; w++) begin
            if (!vic_found && (age_d[l_idx][w] == WW'(N_WAYS - 1))) begin
              vic_found = 1'b1;
              vic_way   = WW'(w);
            end else begin
              vic_found = vic_found;
            end
          end
          ren_d   = 1'b1;
          raddr_d = {l_tag, l_idx, {OB{1'b0}}};
          if (valid_d[l_idx][vic_way] && dirty_d[l_idx][vic_way]) begin
            wen_d   = 1'b1;
            waddr_d = {tag_d[l_idx][vic_way], l_idx, {OB{1'b0}}};
            wline_d = line_d[l_idx][vic_way];
            valid_d[l_idx][vic_way] = 1'b0;
            dirty_d[l_idx][vic_way] = 1'b0;
          end else begin
            wen_d = 1'b0;
          end
          wait_d[l_idx] = 1'b1;
          rtag_d[l_idx] = l_tag;
          vict_d[l_idx] = vic_way;
        end else begin
          ren_d = 1'b0;
        end
        lis_v_d[thread]   = 1'b1;
        lis_idx_d[thread] = l_idx;
        stalled_d[thread] = 1'b1;
      end
    end else begin
      miss_d = 1'b0;
    end
  end

  // Control state and outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s] <= {N_WAYS{1'b0}};
        dirty_q[s] <= {N_WAYS{1'b0}};
        for (int w = 0; w < N_WAYS; w++) age_q[s][w] <= WW'(w);
      end
      wait_q    <= {N_SETS{1'b0}};
      lis_v_q   <= {N_THREADS{1'b0}};
      stalled_q <= {N_THREADS{1'b0}};
      miss_q    <= 1'b0;
      ok_q      <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      data_q    <= 32'h0000_0000;
      raddr_q   <= {PADDR_W{1'b0}};
      waddr_q   <= {PADDR_W{1'b0}};
      wline_q   <= {LW{1'b0}};
    end else begin
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      age_q     <= age_d;
      wait_q    <= wait_d;
      lis_v_q   <= lis_v_d;
      stalled_q <= stalled_d;
      miss_q    <= miss_d;
      ok_q      <= ok_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      data_q    <= data_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wline_q   <= wline_d;
    end
  end

  // Payload arrays are only meaningful under their valid/waiting bits.
  always_ff @(posedge clk) begin
    tag_q     <= tag_d;
    line_q    <= line_d;
    rtag_q    <= rtag_d;
    vict_q    <= vict_d;
    lis_idx_q <= lis_idx_d;
  end

  assign miss                   = miss_q;
  assign data                   = data_q;
  assign stalled                = stalled_q;
  assign store_ok               = ok_q;
  assign mem.mem_req_ren        = ren_q;
  assign mem.mem_req_raddr      = raddr_q;
  assign mem.mem_req_wen        = wen_q;
  assign mem.mem_req_waddr      = waddr_q;
  assign mem.mem_req_wcacheline = wline_q;
endmodule
